rams_3d_stream_reader: RTL
==========================

Name: rams_3d_stream_reader

Overview:
- Read-side initiator for a multi-bank single-port RAM array. There are NUM_RAMS banks, each with per-bank enable, write-enable, address and data-out, and a 1-cycle registered read.
- On a start command it sweeps LEN words, interleaved round-robin across banks from a common base address. The words are emitted on a valid/ready stream with a last flag.
- Sits between the bank array and downstream stream consumers such as DMA, packetiser or UART TX.
- Absorbs read latency under backpressure with a 2-entry skid FIFO.

Parameters:
- NUM_RAMS, 2, number of banks (>=1).
- A_WID, 10, per-bank address width.
- D_WID, 32, data width.
- LEN_WID, 16, width of the transfer length in words.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only when idle.
- base_addr  in  A_WID  starting per-bank address.
- len  in  LEN_WID  number of words to read (0 allowed).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the transfer completes.
- mem_ena  out  [NUM_RAMS-1:0]  per-bank read enable; at most one bit high.
- mem_we  out  [NUM_RAMS-1:0]  tied to all zeros (read-only initiator).
- mem_addr  out  unpacked [NUM_RAMS-1:0] of A_WID  per-bank address; all entries carry the current address.
- mem_dout  in  unpacked [NUM_RAMS-1:0] of D_WID  per-bank registered read data.
- m_data  out  D_WID  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final word; qualified by m_valid.

Behaviour:
- Reset (sync, rst=1 at an edge) drives the following state:
  - Outputs: busy=0, done=0, mem_ena=0, m_valid=0, m_last=0, m_data=0, mem_addr=0.
  - Internals: FIFO emptied; in-flight read flag cleared; FSM to IDLE.
  - Reset mid-transfer discards all in-flight and buffered data; no done pulse.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: if start=1, latch base_addr and len. If len==0, go to IDLE and pulse done next cycle (no reads, busy stays 0). Otherwise go to RUN.
  - RUN: issue reads until LEN reads are issued, then go to DRAIN.
  - DRAIN: when the last word is handshaked (m_valid & m_ready & m_last), pulse done next cycle and go to IDLE.
  - start is ignored outside IDLE.
- Address sequence: word k reads bank (k mod NUM_RAMS) at address (base + floor(k/NUM_RAMS)) mod 2**A_WID.
  - Implemented with a bank counter plus an address counter. The address increments when the bank counter wraps from NUM_RAMS-1 to 0, and wraps 2**A_WID-1 to 0 silently.
  - No dividers.
- Read issue:
  - mem_ena is combinational from FSM state and credit: bit[bank]=1 in RUN when (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready.
  - inflight is a 1-bit flag registered from "issued this cycle".
  - The capture into the FIFO occurs at the edge ending the cycle where inflight=1, taking mem_dout[bank_d], where bank_d is the registered bank index.
- Latency: with start accepted in cycle 0:
  - cycle 1: mem_ena high for the first read;
  - cycle 2: data captured;
  - cycle 3: first m_valid.
- Throughput: 1 word/cycle sustained while m_ready=1.
- FIFO:
  - 2 entries; simultaneous push and pop allowed, including when full.
  - Push never occurs when full; the credit rule guarantees it.
  - m_data/m_valid/m_last come from the head entry.
- Stream rule: m_data and m_last are held stable while m_valid & !m_ready.
- m_last is stored with the entry; it is set for read index LEN-1.
- done:
  - Registered pulse, high in the cycle after the last handshake.
  - busy falls in the same cycle done is high.
  - A new start is accepted in the done cycle.

Decomposition:
- Package rams_3d_pkg:
  - state enum typedef rd_state_t {IDLE, RUN, DRAIN};
  - localparam FIFO_DEPTH = 2;
  - bank-index width function clog2(NUM_RAMS), minimum 1.
- Sub-module rams_3d_rd_fifo: 2-entry skid FIFO, parameterised on data width. Each entry is {last, data}; ports push, pop, full, empty, count.

Test Plan:
Setup for all scenarios: NUM_RAMS=2, A_WID=10, D_WID=32; bank0[i]=i; bank1[i]=0x1000_0000+i; behavioural RAM models have 1-cycle read.
1. base=5, len=4, m_ready=1 -> m_data 0x5, 0x10000005, 0x6, 0x10000006 on consecutive cycles 3..6; m_last only on the 4th word; done in cycle 7; busy cycles 1..6.
2. base=1022, len=6 -> addresses issued 1022(b0), 1022(b1), 1023(b0), 1023(b1), 0(b0), 0(b1); data 0x3FE, 0x100003FE, 0x3FF, 0x100003FF, 0x0, 0x10000000.
3. base=0, len=16, m_ready random 50% -> all 16 words delivered in order with no duplicates or drops; mem_ena=0 whenever the FIFO is full with no pop; data stable during stalls.
4. len=0 with start -> no mem_ena ever; done pulses the cycle after start; busy stays 0; m_valid stays 0.
5. rst=1 after 3 words of a len=8 transfer -> next cycle m_valid=0, busy=0, mem_ena=0, no done. A following start with base=0, len=2 yields 0x0 then 0x10000000 with m_last on the 2nd word.
6. start pulsed with base=100 during a busy transfer (base=0, len=4) -> ignored; output matches the base=0 sequence only; single done.

Source files
------------

// File: rtl/rams_3d_pkg.sv
// Shared types and helpers for the multi-bank RAM stream reader.
package rams_3d_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rd_state_t;

  localparam int unsigned FIFO_DEPTH = 2;

  // Bank-index width; a single bank still needs a 1-bit index.
  function automatic int unsigned bank_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rams_3d_rd_fifo.sv
// Two-entry skid FIFO holding {last, data}; head entry drives the stream.
module rams_3d_rd_fifo
  import rams_3d_pkg::*;
#(
  parameter int unsigned D_WID = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [D_WID-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [D_WID-1:0] data,
  output logic             last,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  localparam int unsigned E_WID = D_WID + 1;

  logic [E_WID-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign {last, data} = mem[rd_ptr];
  assign count        = cnt;
  assign empty        = (cnt == 2'd0);
  assign full         = (cnt == 2'(FIFO_DEPTH));

endmodule

// File: rtl/rams_3d_stream_reader.sv
// Sweeps LEN words round-robin across single-port RAM banks and streams them
// out on valid/ready, using a 2-entry skid FIFO to absorb the read latency.
module rams_3d_stream_reader
  import rams_3d_pkg::*;
#(
  parameter int unsigned NUM_RAMS = 2,
  parameter int unsigned A_WID    = 10,
  parameter int unsigned D_WID    = 32,
  parameter int unsigned LEN_WID  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [A_WID-1:0]    base_addr,
  input  logic [LEN_WID-1:0]  len,
  output logic                busy,
  output logic                done,
  output logic [NUM_RAMS-1:0] mem_ena,
  output logic [NUM_RAMS-1:0] mem_we,
  output logic [A_WID-1:0]    mem_addr [NUM_RAMS-1:0],
  input  logic [D_WID-1:0]    mem_dout [NUM_RAMS-1:0],
  output logic [D_WID-1:0]    m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  localparam int unsigned BW = bank_w(NUM_RAMS);

  rd_state_t          state;
  rd_state_t          state_nxt;
  logic [BW-1:0]      bank;
  logic [BW-1:0]      bank_d;
  logic [A_WID-1:0]   addr;
  logic [LEN_WID-1:0] len_q;
  logic [LEN_WID-1:0] issue_cnt;
  logic               inflight;
  logic               last_d;
  logic               issue;
  logic               last_issue;
  logic               credit_ok;
  logic               done_nxt;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [1:0]         fifo_count;

  assign mem_we     = '0;
  assign m_valid    = ~fifo_empty;
  assign pop        = m_valid & m_ready;
  assign last_issue = (issue_cnt == len_q - LEN_WID'(1));
  // Words owned (in FIFO or in flight) after this cycle's pop must leave a free slot.
  assign credit_ok  = (3'(fifo_count) + 3'(inflight)) < (3'd2 + 3'(pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (len != '0)) state_nxt = RUN;
      RUN:     if (issue && last_issue) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue    = (state == RUN) && credit_ok;
    done_nxt = ((state == IDLE) && start && (len == '0)) ||
               ((state == DRAIN) && pop && m_last);
    mem_ena  = '0;
    for (int i = 0; i < NUM_RAMS; i++) begin
      mem_ena[i]  = issue && (bank == BW'(i));
      mem_addr[i] = addr;
    end
  end

  // Bank counter wraps into an address increment; address wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank      <= '0;
      bank_d    <= '0;
      addr      <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      inflight  <= 1'b0;
      last_d    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done     <= done_nxt;
      busy     <= (state_nxt != IDLE);
      inflight <= issue;
      bank_d   <= bank;
      last_d   <= last_issue;
      if ((state == IDLE) && start) begin
        addr      <= base_addr;
        len_q     <= len;
        bank      <= '0;
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + LEN_WID'(1);
        if (bank == BW'(NUM_RAMS - 1)) begin
          bank <= '0;
          addr <= addr + A_WID'(1);
        end else begin
          bank <= bank + BW'(1);
        end
      end
    end
  end

  rams_3d_rd_fifo #(
    .D_WID(D_WID)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (mem_dout[bank_d]),
    .push_last (last_d),
    .pop       (pop),
    .data      (m_data),
    .last      (m_last),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
